univ_shreg: RTL and testbench
=============================

UNIV_SHREG -- requirements
Module: univ_shreg

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits (WIDTH >= 2).
REQ-002 Parameter CW, default $clog2(WIDTH+1), width of the burst count.
REQ-003 c  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 d  input  WIDTH  parallel load data.
REQ-006 i  input  1  serial input bit.
REQ-007 mode  input  3  operation select: 0 HOLD, 1 LOAD, 2 SHL, 3 SHR, 4 ROL, 5 ROR, 6 ASR, 7 reserved.
REQ-008 en  input  1  single-step enable.
REQ-009 start  input  1  burst request.
REQ-010 cnt  input  CW  burst length in steps.
REQ-011 q  output  WIDTH  register contents.
REQ-012 so_l  output  1  equal to q[WIDTH-1].
REQ-013 so_r  output  1  equal to q[0].
REQ-014 busy  output  1  burst in progress.
REQ-015 done  output  1  one-cycle burst completion pulse.

Function
REQ-016 Step ops SHALL be: HOLD q; LOAD d; SHL {q[W-2:0],i}; SHR {i,q[W-1:1]}; ROL {q[W-2:0],q[W-1]}; ROR {q[0],q[W-1:1]}; ASR {q[W-1],q[W-1:1]}; code 7 SHALL act as HOLD.
REQ-017 FSM states SHALL be IDLE, BUSY, DONE; DONE SHALL last exactly one cycle, then IDLE.
REQ-018 In IDLE or DONE with start=0 and en=1, q SHALL take one step of the current mode at that edge; en=0 holds q.
REQ-019 In IDLE or DONE, start=1 with mode in {SHL,SHR,ROL,ROR,ASR} SHALL latch mode and cnt at that edge with no change to q, overriding en.
REQ-020 start=1 with mode in {HOLD,LOAD,7} SHALL be ignored; en rules apply.
REQ-021 Accepted burst with cnt>0 SHALL enter BUSY and perform exactly cnt steps of the latched mode, one per edge, on the cnt edges following the accept edge.
REQ-022 Accepted burst with cnt=0 SHALL go straight to DONE, q unchanged, busy never asserted.
REQ-023 busy SHALL be 1 exactly while in BUSY; done SHALL be 1 exactly while in DONE.
REQ-024 While BUSY, start, en, mode, cnt and d SHALL be ignored; i SHALL be sampled live at each step edge.
REQ-025 cnt values above WIDTH SHALL be honoured literally (no clamping); rotates wrap naturally.
REQ-026 so_l, so_r SHALL be combinational from q, no added latency.

Reset
REQ-027 rst=1 SHALL immediately force q=0, state IDLE, busy=0, done=0, latched mode/count=0, independent of c.
REQ-028 rst asserted mid-burst SHALL abort the burst with no done pulse.
REQ-029 First edge after rst release SHALL be processed normally per REQ-018/019.

Structure
REQ-030 Package shreg_pkg SHALL hold the mode enum (3-bit) and the FSM state enum.
REQ-031 Step function SHALL be one combinational sub-module shreg_step (WIDTH param; q, d, i, mode in; next q out), instantiated once.
REQ-032 Step counter SHALL be CW bits, decrementing, BUSY exits when it reaches 1 at a step edge.

Verification (WIDTH=8)
REQ-033 rst pulse between edges with q=8'hA5 -> q=8'h00 immediately, busy=0, done=0.
REQ-034 en=1 mode=LOAD d=8'h81, then mode=SHL i=1 one edge -> q=8'h81 then 8'h03.
REQ-035 q=8'h81, start=1 mode=ROR cnt=3 -> busy high 3 cycles, q 8'hC0, 8'h60, 8'h30, then done one cycle.
REQ-036 q=8'h80, burst ASR cnt=4 -> q=8'hF8, done one cycle; mode/en toggled during BUSY have no effect.
REQ-037 start=1 mode=SHL cnt=0 -> done next cycle, busy never 1, q unchanged; start with mode=LOAD -> no burst, LOAD applied only if en=1.
REQ-038 burst SHR cnt=5 with rst asserted after step 2 -> q=0, IDLE, no done pulse.

Source files
------------

// File: rtl/shreg_pkg.sv
// rtl/shreg_pkg.sv - mode and FSM state types for the universal shift register
package shreg_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'd0,
    MODE_LOAD = 3'd1,
    MODE_SHL  = 3'd2,
    MODE_SHR  = 3'd3,
    MODE_ROL  = 3'd4,
    MODE_ROR  = 3'd5,
    MODE_ASR  = 3'd6,
    MODE_RSVD = 3'd7
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Only the shifting/rotating modes make sense as a repeated burst.
  function automatic logic is_burst_mode(input logic [2:0] m);
    return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) ||
           (m == MODE_ROR) || (m == MODE_ASR);
  endfunction

endpackage

// File: rtl/shreg_step.sv
// rtl/shreg_step.sv - combinational single-step next-value function
module shreg_step
  import shreg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  input  logic             i,
  input  mode_e            mode,
  output logic [WIDTH-1:0] q_next
);

  always_comb begin
    q_next = q;
    case (mode)
      MODE_LOAD: q_next = d;
      MODE_SHL:  q_next = {q[WIDTH-2:0], i};
      MODE_SHR:  q_next = {i, q[WIDTH-1:1]};
      MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
      MODE_ASR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
      default:   q_next = q;
    endcase
  end

endmodule

// File: rtl/univ_shreg.sv
// rtl/univ_shreg.sv - universal shift register with single-step and counted bursts
module univ_shreg
  import shreg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             c,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             i,
  input  logic [2:0]       mode,
  input  logic             en,
  input  logic             start,
  input  logic [CW-1:0]    cnt,
  output logic [WIDTH-1:0] q,
  output logic             so_l,
  output logic             so_r,
  output logic             busy,
  output logic             done
);

  state_e            state;
  state_e            state_nxt;
  mode_e             lat_mode;
  logic [CW-1:0]     lat_cnt;
  mode_e             step_mode;
  logic [WIDTH-1:0]  step_q;
  logic              accept;

  assign accept    = (state != ST_BUSY) && start && is_burst_mode(mode);
  // During a burst the latched mode drives the step; otherwise the live mode.
  assign step_mode = (state == ST_BUSY) ? lat_mode : mode_e'(mode);

  shreg_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .q      (q),
    .d      (d),
    .i      (i),
    .mode   (step_mode),
    .q_next (step_q)
  );

  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          state_nxt = (cnt == '0) ? ST_DONE : ST_BUSY;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (lat_cnt == CW'(1)) begin
          state_nxt = ST_DONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_BUSY);
    done = (state == ST_DONE);
  end

  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      q        <= '0;
      lat_mode <= MODE_HOLD;
      lat_cnt  <= '0;
    end else if (state == ST_BUSY) begin
      q       <= step_q;
      lat_cnt <= lat_cnt - CW'(1);
    end else if (accept) begin
      lat_mode <= mode_e'(mode);
      lat_cnt  <= cnt;
    end else if (en) begin
      q <= step_q;
    end
  end

  assign so_l = q[WIDTH-1];
  assign so_r = q[0];

endmodule

// File: tb/tb_univ_shreg.sv
// tb/tb_univ_shreg.sv - vector table, corner sequences and random model check for univ_shreg
module tb_univ_shreg;

  localparam int WIDTH = 8;
  localparam int CW    = 4;

  logic             c;
  logic             rst;
  logic [WIDTH-1:0] d;
  logic             i;
  logic [2:0]       mode;
  logic             en;
  logic             start;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] q;
  logic             so_l;
  logic             so_r;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;

  univ_shreg #(.WIDTH(WIDTH), .CW(CW)) dut (
    .c     (c),
    .rst   (rst),
    .d     (d),
    .i     (i),
    .mode  (mode),
    .en    (en),
    .start (start),
    .cnt   (cnt),
    .q     (q),
    .so_l  (so_l),
    .so_r  (so_r),
    .busy  (busy),
    .done  (done)
  );

  initial c = 1'b0;
  always #5 c = ~c;

  typedef struct {
    logic [2:0]  mode;
    logic        en;
    logic        start;
    logic [3:0]  cnt;
    logic [7:0]  d;
    logic        i;
    logic [7:0]  q;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge c);
    #1;
  endtask

  task automatic drive(input logic [2:0] m, input logic e, input logic s,
                       input logic [3:0] n, input logic [7:0] dv, input logic iv);
    mode = m; en = e; start = s; cnt = n; d = dv; i = iv;
  endtask

  function automatic vec_t mk(input logic [2:0] m, input logic e, input logic s,
                              input logic [3:0] n, input logic [7:0] dv, input logic iv,
                              input logic [7:0] eq, input logic eb, input logic ed);
    vec_t v;
    v.mode = m; v.en = e; v.start = s; v.cnt = n; v.d = dv; v.i = iv;
    v.q = eq; v.busy = eb; v.done = ed;
    return v;
  endfunction

  // Reference: arithmetic view of one step on an 8-bit value.
  function automatic int ref_op(input int m, input int qv, input int dv, input int iv);
    case (m)
      1: return dv;
      2: return (qv * 2 + iv) % 256;
      3: return qv / 2 + iv * 128;
      4: return (qv * 2) % 256 + qv / 128;
      5: return qv / 2 + (qv % 2) * 128;
      6: return qv / 2 + (qv / 128) * 128;
      default: return qv;
    endcase
  endfunction

  int m_q, m_left, m_bmode;
  bit m_done;

  task automatic model_edge(input int mv, input int ev, input int sv, input int nv,
                            input int dv, input int iv);
    if (m_left > 0) begin
      m_q = ref_op(m_bmode, m_q, dv, iv);
      m_left--;
      m_done = (m_left == 0);
    end else begin
      m_done = 0;
      if (sv != 0 && mv >= 2 && mv <= 6) begin
        m_bmode = mv;
        if (nv == 0) m_done = 1;
        else m_left = nv;
      end else if (ev != 0) begin
        m_q = ref_op(mv, m_q, dv, iv);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(3'd0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    #12;
    check("reset_q", q, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    @(negedge c);
    rst = 1'b0;
    #1;

    // Async reset between edges
    drive(3'd1, 1'b1, 1'b0, 4'd0, 8'hA5, 1'b0);
    tick();
    check("load_a5", q, 8'hA5);
    drive(3'd0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    #1 rst = 1'b1;
    #1;
    check("async_rst_q", q, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    #1 rst = 1'b0;

    // Table vectors
    tbl.push_back(mk(3'd1, 1, 0, 0, 8'h81, 0, 8'h81, 0, 0));
    tbl.push_back(mk(3'd2, 1, 0, 0, 8'h00, 1, 8'h03, 0, 0));
    tbl.push_back(mk(3'd1, 1, 0, 0, 8'h81, 0, 8'h81, 0, 0));
    tbl.push_back(mk(3'd5, 0, 1, 3, 8'h00, 0, 8'h81, 1, 0));
    tbl.push_back(mk(3'd0, 1, 0, 0, 8'hFF, 1, 8'hC0, 1, 0));
    tbl.push_back(mk(3'd1, 1, 1, 7, 8'hFF, 0, 8'h60, 1, 0));
    tbl.push_back(mk(3'd0, 0, 0, 0, 8'h00, 0, 8'h30, 0, 1));
    tbl.push_back(mk(3'd0, 0, 0, 0, 8'h00, 0, 8'h30, 0, 0));
    tbl.push_back(mk(3'd2, 1, 1, 0, 8'h00, 1, 8'h30, 0, 1));
    tbl.push_back(mk(3'd1, 0, 1, 5, 8'hFF, 0, 8'h30, 0, 0));
    tbl.push_back(mk(3'd1, 1, 1, 5, 8'h5A, 0, 8'h5A, 0, 0));
    tbl.push_back(mk(3'd1, 1, 0, 0, 8'h80, 0, 8'h80, 0, 0));
    tbl.push_back(mk(3'd6, 0, 1, 4, 8'h00, 0, 8'h80, 1, 0));
    tbl.push_back(mk(3'd1, 1, 0, 0, 8'h00, 0, 8'hC0, 1, 0));
    tbl.push_back(mk(3'd2, 1, 1, 2, 8'h00, 1, 8'hE0, 1, 0));
    tbl.push_back(mk(3'd4, 0, 0, 0, 8'h00, 0, 8'hF0, 1, 0));
    tbl.push_back(mk(3'd0, 0, 0, 0, 8'h00, 0, 8'hF8, 0, 1));
    tbl.push_back(mk(3'd4, 0, 1, 9, 8'h00, 0, 8'hF8, 1, 0));
    tbl.push_back(mk(3'd0, 0, 0, 0, 8'h00, 0, 8'hF1, 1, 0));
    tbl.push_back(mk(3'd0, 0, 0, 0, 8'h00, 0, 8'hE3, 1, 0));
    tbl.push_back(mk(3'd0, 0, 0, 0, 8'h00, 0, 8'hC7, 1, 0));
    tbl.push_back(mk(3'd0, 0, 0, 0, 8'h00, 0, 8'h8F, 1, 0));
    tbl.push_back(mk(3'd0, 0, 0, 0, 8'h00, 0, 8'h1F, 1, 0));
    tbl.push_back(mk(3'd0, 0, 0, 0, 8'h00, 0, 8'h3E, 1, 0));
    tbl.push_back(mk(3'd0, 0, 0, 0, 8'h00, 0, 8'h7C, 1, 0));
    tbl.push_back(mk(3'd0, 0, 0, 0, 8'h00, 0, 8'hF8, 1, 0));
    tbl.push_back(mk(3'd0, 0, 0, 0, 8'h00, 0, 8'hF1, 0, 1));
    tbl.push_back(mk(3'd7, 1, 1, 3, 8'h00, 1, 8'hF1, 0, 0));
    tbl.push_back(mk(3'd3, 1, 0, 0, 8'h00, 0, 8'h78, 0, 0));

    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].mode, tbl[k].en, tbl[k].start, tbl[k].cnt, tbl[k].d, tbl[k].i);
      tick();
      check($sformatf("vec%0d_q", k), q, tbl[k].q);
      check($sformatf("vec%0d_busy", k), busy, tbl[k].busy);
      check($sformatf("vec%0d_done", k), done, tbl[k].done);
      check($sformatf("vec%0d_so_l", k), so_l, tbl[k].q[7]);
      check($sformatf("vec%0d_so_r", k), so_r, tbl[k].q[0]);
    end

    // Reset in the middle of an SHR burst: abort, no done pulse afterwards
    drive(3'd1, 1'b1, 1'b0, 4'd0, 8'hFF, 1'b0);
    tick();
    drive(3'd3, 1'b0, 1'b1, 4'd5, 8'h00, 1'b0);
    tick();
    drive(3'd0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    tick();
    tick();
    check("abort_pre_q", q, 8'h3F);
    check("abort_pre_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("abort_q", q, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    tick();
    #2 rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("abort_nodone%0d", k), done, 0);
      check($sformatf("abort_nobusy%0d", k), busy, 0);
    end
    drive(3'd1, 1'b1, 1'b0, 4'd0, 8'h3C, 1'b0);
    tick();
    check("post_rst_load", q, 8'h3C);

    // Randomized run against the reference model
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    m_q = 0; m_left = 0; m_bmode = 0; m_done = 0;
    for (int k = 0; k < 800; k++) begin
      int mv, ev, sv, nv, dv, iv;
      mv = $urandom_range(0, 7);
      ev = $urandom_range(0, 1);
      sv = ($urandom_range(0, 3) == 0) ? 1 : 0;
      nv = $urandom_range(0, 12);
      dv = $urandom_range(0, 255);
      iv = $urandom_range(0, 1);
      drive(mv[2:0], ev[0], sv[0], nv[3:0], dv[7:0], iv[0]);
      tick();
      model_edge(mv, ev, sv, nv, dv, iv);
      check($sformatf("rnd%0d_q", k), q, m_q);
      check($sformatf("rnd%0d_busy", k), busy, (m_left > 0) ? 1 : 0);
      check($sformatf("rnd%0d_done", k), done, m_done ? 1 : 0);
      check($sformatf("rnd%0d_so_l", k), so_l, m_q / 128);
      check($sformatf("rnd%0d_so_r", k), so_r, m_q % 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
